// File: rtl/vmem_arb_ctrl.sv
`default_nettype none
// ============================================================================
// vmem_arb_ctrl : round-robin multi-channel arbiter fronting a byte-writable
//                 single-port RAM with registered acknowledge and read data.
// Revision      : 1.0
// ============================================================================
module vmem_arb_ctrl #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 512,
    parameter  int NUM_CH = 2,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]   ch_be,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [DATA_W-1:0]        ack_rdata,
    output logic                     ack_err
);

    localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]   last_q, last_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              rd_ok_q, rd_ok_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0] gnt;
    logic              gnt_any;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              in_range;
    logic [ADDR_W-1:0] mem_idx;
    logic              wr_en;
    logic              rd_en;

    // Search starts one past the last winner and wraps at NUM_CH, which need
    // not be a power of two.
    always_comb begin : arbitrate
        gnt     = '0;
        gnt_any = 1'b0;
        win     = last_q;
        cand    = last_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
            if (!gnt_any && rst_n && ch_req[cand]) begin
                gnt_any = 1'b1;
                win     = cand;
            end
        end
        if (gnt_any) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin : select
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_we    = ch_we[i];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
                sel_be    = ch_be[i*BE_W +: BE_W];
            end
        end
    end

    // Out-of-range addresses never reach the array, so no aliasing can occur.
    always_comb begin : decode
        in_range = (32'(sel_addr) < 32'(DEPTH));
        mem_idx  = in_range ? sel_addr : '0;
        wr_en    = gnt_any & sel_we & in_range;
        rd_en    = gnt_any & ~sel_we & in_range;
        last_d   = gnt_any ? win : last_q;
        ack_d    = gnt;
        rd_ok_d  = rd_en;
        err_d    = gnt_any & ~in_range;
    end

    always_ff @(posedge clk) begin : ram
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            mem_rd_q <= mem[mem_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
        if (!rst_n) begin
            last_q  <= LAST_CH;
            ack_q   <= '0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            ack_q   <= ack_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
        end
    end

    // Read data is forced to zero unless this ack belongs to a valid read.
    assign ch_gnt    = gnt;
    assign ch_ack    = ack_q;
    assign ack_err   = err_q;
    assign ack_rdata = rd_ok_q ? mem_rd_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_vmem_arb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vmem_arb_ctrl : directed scoreboard bench for vmem_arb_ctrl, using a
//                    2-channel default instance and a 4-channel DEPTH=500 one.
// Revision         : 1.0
// ============================================================================
module tb_vmem_arb_ctrl;

    typedef struct {
        logic [3:0]   gnt;
        logic [127:0] rdata;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]   a_req, a_we, a_gnt, a_ack;
    logic [17:0]  a_addr;
    logic [255:0] a_wdata;
    logic [31:0]  a_be;
    logic [127:0] a_rdata;
    logic         a_err;

    logic [3:0]   b_req, b_we, b_gnt, b_ack;
    logic [35:0]  b_addr;
    logic [511:0] b_wdata;
    logic [63:0]  b_be;
    logic [127:0] b_rdata;
    logic         b_err;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [127:0] V1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] V2   = {{120{1'b1}}, 8'h00};
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] D10  = 128'h1010_0000_AAAA_5555_0F0F_F0F0_1234_5678;
    localparam logic [127:0] D498 = 128'h4980_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] D499 = 128'h4990_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

    vmem_arb_ctrl #(.DATA_W(128), .DEPTH(512), .NUM_CH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr),
        .ch_wdata(a_wdata), .ch_be(a_be), .ch_gnt(a_gnt), .ch_ack(a_ack),
        .ack_rdata(a_rdata), .ack_err(a_err)
    );

    vmem_arb_ctrl #(.DATA_W(128), .DEPTH(500), .NUM_CH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr),
        .ch_wdata(b_wdata), .ch_be(b_be), .ch_gnt(b_gnt), .ch_ack(b_ack),
        .ack_rdata(b_rdata), .ack_err(b_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input int ch, input logic req, input logic we, input logic [8:0] addr,
                         input logic [127:0] wd, input logic [15:0] be);
        a_req[ch]            = req;
        a_we[ch]             = we;
        a_addr[ch*9 +: 9]    = addr;
        a_wdata[ch*128 +: 128] = wd;
        a_be[ch*16 +: 16]    = be;
    endtask

    task automatic drv_b(input int ch, input logic req, input logic we, input logic [8:0] addr,
                         input logic [127:0] wd, input logic [15:0] be);
        b_req[ch]            = req;
        b_we[ch]             = we;
        b_addr[ch*9 +: 9]    = addr;
        b_wdata[ch*128 +: 128] = wd;
        b_be[ch*16 +: 16]    = be;
    endtask

    // One clock of instance A: check the grant, queue its ack, then check the ack.
    task automatic step_a(input string tag, input logic [3:0] eg, input logic [127:0] er, input logic ee);
        exp_t e;
        #1;
        chk({tag, "_gnt"}, 128'(a_gnt), 128'(eg));
        if (eg != 4'd0) qa.push_back('{eg, er, ee});
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk({tag, "_ack"},   128'(a_ack), 128'(e.gnt));
            chk({tag, "_rdata"}, a_rdata,     e.rdata);
            chk({tag, "_err"},   128'(a_err), 128'(e.err));
        end else begin
            chk({tag, "_noack"},   128'(a_ack), 128'(0));
            chk({tag, "_norddata"}, a_rdata,    128'(0));
            chk({tag, "_noerr"},   128'(a_err), 128'(0));
        end
    endtask

    task automatic step_b(input string tag, input logic [3:0] eg, input logic [127:0] er, input logic ee);
        exp_t e;
        #1;
        chk({tag, "_gnt"}, 128'(b_gnt), 128'(eg));
        if (eg != 4'd0) qb.push_back('{eg, er, ee});
        @(posedge clk);
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk({tag, "_ack"},   128'(b_ack), 128'(e.gnt));
            chk({tag, "_rdata"}, b_rdata,     e.rdata);
            chk({tag, "_err"},   128'(b_err), 128'(e.err));
        end else begin
            chk({tag, "_noack"},    128'(b_ack), 128'(0));
            chk({tag, "_nordata"},  b_rdata,     128'(0));
            chk({tag, "_noerr"},    128'(b_err), 128'(0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
        a_req = 2'b11;
        b_req = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_gnt",   128'(a_gnt), 128'(0));
        chk("rst_b_gnt",   128'(b_gnt), 128'(0));
        chk("rst_a_ack",   128'(a_ack), 128'(0));
        chk("rst_a_rdata", a_rdata,     128'(0));
        chk("rst_a_err",   128'(a_err), 128'(0));
        chk("rst_b_ack",   128'(b_ack), 128'(0));
        a_req = '0;
        b_req = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read-back on consecutive cycles.
        drv_a(0, 1, 1, 9'd5, V1, 16'hFFFF);
        step_a("wr5", 4'b0001, 128'(0), 1'b0);
        drv_a(0, 1, 0, 9'd5, '0, 16'h0000);
        step_a("rd5", 4'b0001, V1, 1'b0);

        // Byte-enable partial write, then an all-zero-BE write that must not land.
        drv_a(0, 1, 1, 9'd7, ONES, 16'hFFFF);
        step_a("wr7_ones", 4'b0001, 128'(0), 1'b0);
        drv_a(0, 1, 1, 9'd7, '0, 16'h0001);
        step_a("wr7_be0", 4'b0001, 128'(0), 1'b0);
        drv_a(0, 1, 0, 9'd7, '0, 16'h0000);
        step_a("rd7", 4'b0001, V2, 1'b0);
        drv_a(0, 1, 1, 9'd7, '0, 16'h0000);
        step_a("wr7_nobe", 4'b0001, 128'(0), 1'b0);
        drv_a(0, 1, 0, 9'd7, '0, 16'h0000);
        step_a("rd7_again", 4'b0001, V2, 1'b0);
        drv_a(0, 0, 0, 9'd0, '0, 16'h0000);
        step_a("idle_a", 4'b0000, 128'(0), 1'b0);

        // Reset lands in the middle of a granted cycle.
        drv_a(0, 1, 1, 9'd20, V1, 16'hFFFF);
        #1;
        chk("pre_rst_gnt", 128'(a_gnt), 128'(2'b01));
        #2 rst_n = 1'b0;
        #1;
        chk("in_rst_gnt", 128'(a_gnt), 128'(0));
        drv_a(0, 0, 0, 9'd0, '0, 16'h0000);
        @(posedge clk);
        #1;
        chk("in_rst_ack", 128'(a_ack), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ack", 128'(a_ack), 128'(0));

        // Continuous contention alternates with no idle cycle.
        drv_a(0, 1, 0, 9'd5, '0, 16'h0000);
        drv_a(1, 1, 0, 9'd7, '0, 16'h0000);
        step_a("rr0", 4'b0001, V1, 1'b0);
        step_a("rr1", 4'b0010, V2, 1'b0);
        step_a("rr2", 4'b0001, V1, 1'b0);
        step_a("rr3", 4'b0010, V2, 1'b0);
        a_req = '0;
        step_a("idle_a2", 4'b0000, 128'(0), 1'b0);

        // Out-of-range accesses on the DEPTH=500 instance.
        drv_b(0, 1, 1, 9'd10, D10, 16'hFFFF);
        step_b("b_wr10", 4'b0001, 128'(0), 1'b0);
        drv_b(0, 1, 1, 9'd498, D498, 16'hFFFF);
        step_b("b_wr498", 4'b0001, 128'(0), 1'b0);
        drv_b(0, 1, 1, 9'd499, D499, 16'hFFFF);
        step_b("b_wr499", 4'b0001, 128'(0), 1'b0);
        drv_b(0, 0, 0, 9'd0, '0, 16'h0000);
        drv_b(1, 1, 0, 9'd510, '0, 16'h0000);
        step_b("b_rd510", 4'b0010, 128'(0), 1'b1);
        drv_b(1, 0, 0, 9'd0, '0, 16'h0000);
        drv_b(2, 1, 1, 9'd510, ONES, 16'hFFFF);
        step_b("b_wr510", 4'b0100, 128'(0), 1'b1);
        drv_b(2, 0, 0, 9'd0, '0, 16'h0000);
        drv_b(3, 1, 0, 9'd10, '0, 16'h0000);
        step_b("b_rd10", 4'b1000, D10, 1'b0);
        drv_b(3, 1, 0, 9'd498, '0, 16'h0000);
        step_b("b_rd498", 4'b1000, D498, 1'b0);
        drv_b(3, 1, 0, 9'd499, '0, 16'h0000);
        step_b("b_rd499", 4'b1000, D499, 1'b0);
        drv_b(3, 1, 0, 9'd510, '0, 16'h0000);
        step_b("b_rd510b", 4'b1000, 128'(0), 1'b1);

        // All four request at once: each served exactly once within four cycles.
        drv_b(0, 1, 0, 9'd10,  '0, 16'h0000);
        drv_b(1, 1, 0, 9'd498, '0, 16'h0000);
        drv_b(2, 1, 0, 9'd499, '0, 16'h0000);
        drv_b(3, 1, 0, 9'd10,  '0, 16'h0000);
        step_b("b_all0", 4'b0001, D10, 1'b0);
        b_req[0] = 1'b0;
        step_b("b_all1", 4'b0010, D498, 1'b0);
        b_req[1] = 1'b0;
        step_b("b_all2", 4'b0100, D499, 1'b0);
        b_req[2] = 1'b0;
        step_b("b_all3", 4'b1000, D10, 1'b0);
        b_req[3] = 1'b0;
        step_b("b_idle", 4'b0000, 128'(0), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
